// File: rtl/pipe_pkg.sv
// Shared constants for the pipe_chain register pipeline.
package pipe_pkg;
    localparam logic [4:0]  XZR      = 5'd31;
    localparam int unsigned SEL_NONE = 0;
endpackage

// File: rtl/pipe_chain_if.sv
// One pipeline entry bundle: master drives an entry, slave consumes it.
interface pipe_chain_if #(
    parameter int WIDTH = 64,
    parameter int REGW  = 5
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [REGW-1:0]  rd;
    logic             wr;
    logic             load;

    modport master (output valid, data, rd, wr, load);
    modport slave  (input  valid, data, rd, wr, load);
endinterface

// File: rtl/pipe_chain_stage_reg.sv
// Single pipeline stage: entry register with load enable and in-place valid clear.
module stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int REGW  = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    pipe_chain_if.slave  d,
    pipe_chain_if.master q
);
    localparam int TOP = WIDTH + REGW + 2;

    logic [TOP:0] r;

    always_ff @(posedge clk) begin
        if (reset)
            r <= '0;
        else if (en)
            r <= {d.valid, d.wr, d.load, d.rd, d.data};
        else if (clr)
            r[TOP] <= 1'b0;
    end

    assign {q.valid, q.wr, q.load, q.rd, q.data} = r;
endmodule

// File: rtl/pipe_chain.sv
// Stallable, flushable register pipeline with operand forwarding, load-use hazard and occupancy count.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = 64,
    parameter  int STAGES = 3,
    parameter  int REGW   = 5,
    localparam int SELW   = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [REGW-1:0]   in_rd,
    input  logic              in_wr,
    input  logic              in_load,
    input  logic              stall,
    input  logic [STAGES-1:0] flush,
    input  logic [REGW-1:0]   src_a,
    input  logic [REGW-1:0]   src_b,
    output logic [SELW-1:0]   fwd_a_sel,
    output logic [SELW-1:0]   fwd_b_sel,
    output logic [WIDTH-1:0]  fwd_a_data,
    output logic [WIDTH-1:0]  fwd_b_data,
    output logic              hazard,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [REGW-1:0]   out_rd,
    output logic              out_wr,
    output logic              out_fire,
    output logic [SELW-1:0]   occupancy
);
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] wr;
    logic [STAGES-2:0] ld;
    logic [WIDTH-1:0]  dat [STAGES];
    logic [REGW-1:0]   rdv [STAGES];
    logic [STAGES-1:0] match_a;
    logic [STAGES-1:0] match_b;
    logic              accept;

    pipe_chain_if #(.WIDTH(WIDTH), .REGW(REGW)) d_bus [STAGES] ();
    pipe_chain_if #(.WIDTH(WIDTH), .REGW(REGW)) q_bus [STAGES] ();

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign d_bus[k].valid = accept;
            assign d_bus[k].data  = in_data;
            assign d_bus[k].rd    = in_rd;
            assign d_bus[k].wr    = in_wr;
            assign d_bus[k].load  = in_load;
        end else begin : g_body
            // flush[k-1] kills the entry as it moves into stage k
            assign d_bus[k].valid = v[k-1] & ~flush[k-1];
            assign d_bus[k].data  = dat[k-1];
            assign d_bus[k].rd    = rdv[k-1];
            assign d_bus[k].wr    = wr[k-1];
            assign d_bus[k].load  = ld[k-1];
        end

        stage_reg #(.WIDTH(WIDTH), .REGW(REGW)) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (~stall),
            .clr   (stall & flush[k]),
            .d     (d_bus[k]),
            .q     (q_bus[k])
        );

        assign v[k]   = q_bus[k].valid;
        assign wr[k]  = q_bus[k].wr;
        assign dat[k] = q_bus[k].data;
        assign rdv[k] = q_bus[k].rd;
        if (k < STAGES - 1) begin : g_ld
            assign ld[k] = q_bus[k].load;
        end

        // flushed entries still match; XZR never does
        assign match_a[k] = v[k] & wr[k] & (rdv[k] == src_a) & (rdv[k] != REGW'(XZR));
        assign match_b[k] = v[k] & wr[k] & (rdv[k] == src_b) & (rdv[k] != REGW'(XZR));
    end

    always_comb begin
        logic found_a;
        logic found_b;
        found_a    = 1'b0;
        found_b    = 1'b0;
        fwd_a_sel  = SELW'(SEL_NONE);
        fwd_b_sel  = SELW'(SEL_NONE);
        fwd_a_data = '0;
        fwd_b_data = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (match_a[i] && !found_a) begin
                found_a    = 1'b1;
                fwd_a_sel  = SELW'(i + 1);
                fwd_a_data = dat[i];
            end
            if (match_b[i] && !found_b) begin
                found_b    = 1'b1;
                fwd_b_sel  = SELW'(i + 1);
                fwd_b_data = dat[i];
            end
        end
    end

    assign hazard   = in_valid & ((match_a[0] & ld[0]) | (match_b[0] & ld[0]));
    assign in_ready = ~stall & ~hazard;
    assign accept   = in_valid & in_ready;

    assign out_valid = v[STAGES-1];
    assign out_data  = dat[STAGES-1];
    assign out_rd    = rdv[STAGES-1];
    assign out_wr    = wr[STAGES-1];
    assign out_fire  = out_valid & ~stall & ~flush[STAGES-1];

    // Every flushed valid stage leaves (advance or hold); a valid last stage leaves
    // either by firing or by being flushed, so this keeps occupancy == popcount(v).
    logic [SELW-1:0] occ_next;
    always_comb begin
        int n;
        int drop;
        drop = 0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (v[i] && flush[i]) drop++;
        end
        n = int'(occupancy) + int'(accept) - int'(out_fire) - drop;
        if (n < 0) n = 0;
        if (n > STAGES) n = STAGES;
        occ_next = SELW'(n);
    end

    always_ff @(posedge clk) begin
        if (reset)
            occupancy <= '0;
        else
            occupancy <= occ_next;
    end
endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (STAGES=3, WIDTH=64) with hand-computed expectations.
module tb_pipe_chain;
    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  flush;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic        in_ready;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [63:0] fwd_a_data;
    logic [63:0] fwd_b_data;
    logic        hazard;
    logic        out_valid;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wr;
    logic        out_fire;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    pipe_chain_if #(.WIDTH(64), .REGW(5)) src ();

    pipe_chain #(.WIDTH(64), .STAGES(3), .REGW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (src.valid),
        .in_ready   (in_ready),
        .in_data    (src.data),
        .in_rd      (src.rd),
        .in_wr      (src.wr),
        .in_load    (src.load),
        .stall      (stall),
        .flush      (flush),
        .src_a      (src_a),
        .src_b      (src_b),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .fwd_a_data (fwd_a_data),
        .fwd_b_data (fwd_b_data),
        .hazard     (hazard),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .out_wr     (out_wr),
        .out_fire   (out_fire),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [63:0] d, input logic [4:0] rd,
                         input logic w, input logic l);
        src.valid = v;
        src.data  = d;
        src.rd    = rd;
        src.wr    = w;
        src.load  = l;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 3'b000;
        src_a = 5'd0;
        src_b = 5'd0;
        offer(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_fire", out_fire, 1'b0);
        chk("rst_occ", occupancy, 2'd0);
        chk("rst_hazard", hazard, 1'b0);
        chk("rst_fwd_a_sel", fwd_a_sel, 2'd0);
        chk("rst_fwd_b_sel", fwd_b_sel, 2'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        stall = 1'b1;
        #1;
        chk("rst_in_ready_stall", in_ready, 1'b0);
        stall = 1'b0;

        // fill with three identical entries, then drain
        offer(1'b1, 64'hA, 5'd3, 1'b1, 1'b0);
        tick();
        chk("fill_occ1", occupancy, 2'd1);
        chk("fill_ov1", out_valid, 1'b0);
        tick();
        chk("fill_occ2", occupancy, 2'd2);
        chk("fill_ov2", out_valid, 1'b0);
        tick();
        chk("fill_ov3", out_valid, 1'b1);
        chk("fill_fire3", out_fire, 1'b1);
        chk("fill_data", out_data, 64'hA);
        chk("fill_rd", out_rd, 5'd3);
        chk("fill_wr", out_wr, 1'b1);
        chk("fill_occ3", occupancy, 2'd3);
        offer(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        src_a = 5'd3;
        #1;
        chk("fill_fwd_sel", fwd_a_sel, 2'd1);
        chk("fill_fwd_data", fwd_a_data, 64'hA);
        tick();
        chk("drain_fire4", out_fire, 1'b1);
        chk("drain_occ4", occupancy, 2'd2);
        tick();
        chk("drain_fire5", out_fire, 1'b1);
        chk("drain_occ5", occupancy, 2'd1);
        tick();
        chk("drain_ov6", out_valid, 1'b0);
        chk("drain_occ6", occupancy, 2'd0);

        // load-use hazard
        src_a = 5'd0;
        offer(1'b1, 64'h55, 5'd5, 1'b1, 1'b1);
        tick();
        offer(1'b1, 64'h66, 5'd9, 1'b1, 1'b0);
        src_a = 5'd5;
        #1;
        chk("lu_hazard", hazard, 1'b1);
        chk("lu_in_ready", in_ready, 1'b0);
        chk("lu_sel0", fwd_a_sel, 2'd1);
        chk("lu_data0", fwd_a_data, 64'h55);
        tick();
        chk("lu_hazard_clr", hazard, 1'b0);
        chk("lu_sel1", fwd_a_sel, 2'd2);
        chk("lu_data1", fwd_a_data, 64'h55);
        chk("lu_in_ready1", in_ready, 1'b1);
        chk("lu_occ", occupancy, 2'd1);
        offer(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("lu_sel2", fwd_a_sel, 2'd3);
        tick();
        chk("lu_occ_empty", occupancy, 2'd0);

        // forwarding priority and XZR
        src_a = 5'd0;
        offer(1'b1, 64'h77, 5'd7, 1'b1, 1'b0);
        tick();
        offer(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        tick();
        offer(1'b1, 64'h99, 5'd7, 1'b1, 1'b0);
        tick();
        offer(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        src_a = 5'd7;
        src_b = 5'd7;
        #1;
        chk("pri_b_sel", fwd_b_sel, 2'd1);
        chk("pri_b_data", fwd_b_data, 64'h99);
        chk("pri_a_sel", fwd_a_sel, 2'd1);
        chk("pri_a_data", fwd_a_data, 64'h99);
        chk("pri_occ", occupancy, 2'd2);
        offer(1'b1, 64'h31, 5'd31, 1'b1, 1'b0);
        tick();
        offer(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        src_b = 5'd31;
        #1;
        chk("xzr_b_sel", fwd_b_sel, 2'd0);
        chk("xzr_b_data", fwd_b_data, 64'h0);
        chk("xzr_occ", occupancy, 2'd2);
        src_a = 5'd0;
        src_b = 5'd0;
        tick();
        tick();
        tick();
        chk("pri_drain_occ", occupancy, 2'd0);

        // stall holds a full pipe; flush during stall clears in place
        offer(1'b1, 64'h1, 5'd10, 1'b1, 1'b0);
        tick();
        offer(1'b1, 64'h2, 5'd11, 1'b1, 1'b0);
        tick();
        offer(1'b1, 64'h3, 5'd12, 1'b1, 1'b0);
        tick();
        offer(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        stall = 1'b1;
        src_a = 5'd11;
        #1;
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_fire0", out_fire, 1'b0);
        tick();
        tick();
        tick();
        tick();
        chk("stall_occ", occupancy, 2'd3);
        chk("stall_ov", out_valid, 1'b1);
        chk("stall_data", out_data, 64'h1);
        chk("stall_rd", out_rd, 5'd10);
        chk("stall_fire", out_fire, 1'b0);
        chk("stall_fwd_sel", fwd_a_sel, 2'd2);
        chk("stall_fwd_data", fwd_a_data, 64'h2);
        flush = 3'b010;
        #1;
        chk("sflush_ov_comb", out_valid, 1'b1);
        tick();
        chk("sflush_occ", occupancy, 2'd2);
        chk("sflush_fwd_sel", fwd_a_sel, 2'd0);
        chk("sflush_ov", out_valid, 1'b1);
        flush = 3'b000;
        stall = 1'b0;
        #1;
        chk("unstall_fire", out_fire, 1'b1);

        // full flush while accepting a new entry
        flush = 3'b111;
        offer(1'b1, 64'hF0, 5'd4, 1'b1, 1'b0);
        #1;
        chk("flush_fire", out_fire, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        tick();
        flush = 3'b000;
        src_a = 5'd4;
        #1;
        chk("flush_occ", occupancy, 2'd1);
        chk("flush_ov", out_valid, 1'b0);
        chk("flush_fwd_sel", fwd_a_sel, 2'd1);
        chk("flush_fwd_data", fwd_a_data, 64'hF0);
        offer(1'b1, 64'hF1, 5'd4, 1'b1, 1'b0);
        tick();
        offer(1'b1, 64'hF2, 5'd4, 1'b1, 1'b0);
        tick();
        chk("refill_occ", occupancy, 2'd3);
        chk("refill_data", out_data, 64'hF0);

        // reset mid-operation
        offer(1'b1, 64'hF3, 5'd4, 1'b1, 1'b0);
        src_b = 5'd4;
        reset = 1'b1;
        tick();
        chk("mrst_occ", occupancy, 2'd0);
        chk("mrst_ov", out_valid, 1'b0);
        chk("mrst_fire", out_fire, 1'b0);
        chk("mrst_a_sel", fwd_a_sel, 2'd0);
        chk("mrst_b_sel", fwd_b_sel, 2'd0);
        chk("mrst_hazard", hazard, 1'b0);
        reset = 1'b0;
        offer(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("post_rst_occ", occupancy, 2'd0);
        chk("post_rst_ov", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter WIDTH, default 64, giving the payload width.
REQ-003 The block SHALL have parameter STAGES, default 3, giving the pipeline depth; legal range is 2..8.
REQ-004 The block SHALL have parameter REGW, default 5, giving the register-address width.
REQ-005 The block SHALL have parameter SELW = $clog2(STAGES+1), which is derived and not user-set.
REQ-006 The block SHALL have these ports, in this order:
  clk  in  1  clock; all state updates on its rising edge
  reset  in  1  synchronous, active-high reset
  in_valid  in  1  new entry offered
  in_ready  out  1  entry accepted this cycle; equals ~stall & ~hazard
  in_data  in  WIDTH  payload
  in_rd  in  REGW  destination register
  in_wr  in  1  entry writes in_rd
  in_load  in  1  entry is a load; result not available until it leaves stage 0
  stall  in  1  hold all stages
  flush  in  STAGES  per-stage kill
  src_a  in  REGW  consumer operand A address
  src_b  in  REGW  consumer operand B address
  fwd_a_sel  out  SELW  0 = no match, k+1 = match in stage k
  fwd_b_sel  out  SELW  0 = no match, k+1 = match in stage k
  fwd_a_data  out  WIDTH  payload of the matched stage for A, else 0
  fwd_b_data  out  WIDTH  payload of the matched stage for B, else 0
  hazard  out  1  load-use stall request
  out_valid  out  1  last-stage entry valid
  out_data  out  WIDTH  last-stage payload
  out_rd  out  REGW  last-stage destination
  out_wr  out  1  last-stage write flag
  out_fire  out  1  last-stage entry retires this cycle
  occupancy  out  SELW  registered count of valid stages

Function
REQ-007 Each stage SHALL hold {valid, data, rd, wr, load}; stage 0 is youngest and stage STAGES-1 is oldest.
REQ-008 Advance: when stall=0, each stage k>0 SHALL load stage k-1, with valid cleared if flush[k-1]=1.
REQ-009 When stall=0, stage 0 SHALL load the input if in_valid & in_ready, else a bubble (valid=0).
REQ-010 Hold: when stall=1, every stage SHALL keep its contents, except that flush[k]=1 clears stage k's valid in place.
REQ-011 When stall=0 and hazard=1, stage 0 SHALL receive a bubble and the input SHALL not be accepted; in_ready is 0.
REQ-012 out_* SHALL be driven directly from the stage STAGES-1 register, with no combinational path from flush or stall into out_valid.
REQ-013 out_fire SHALL equal out_valid & ~stall & ~flush[STAGES-1].
REQ-014 Fill latency: an entry accepted at edge N SHALL appear on out_* after edge N+STAGES-1, when there is no stall.
REQ-015 Forwarding: the block SHALL select the lowest-index stage k with valid & wr & (rd==src) & (rd!=5'd31); XZR never matches.
REQ-016 When no stage matches, fwd_*_sel SHALL be 0 and fwd_*_data SHALL be 0.
REQ-017 Entries marked by flush this cycle SHALL still participate in matching (conservative).
REQ-018 hazard SHALL equal in_valid & ((A match at stage 0 & stage0.load) | (B match at stage 0 & stage0.load)).
REQ-019 A load in stage k≥1 SHALL forward normally.
REQ-020 When src_a==src_b, both channels SHALL report the identical selection.
REQ-021 occupancy SHALL be a counter updated by (+1 on entry accept) (−1 on out_fire) (−1 per flushed valid stage k<STAGES-1 on advance, or per flushed valid stage in hold).
REQ-022 occupancy SHALL always equal the popcount of stage valids.
REQ-023 Simultaneous accept, retire and flush SHALL net out in a single cycle.
REQ-024 occupancy SHALL not wrap; STAGES is its maximum value.

Reset
REQ-025 When reset=1 at a rising edge, all stage valid, data, rd, wr and load SHALL be cleared to 0.
REQ-026 Reset SHALL clear occupancy to 0.
REQ-027 Reset SHALL override stall, flush and input acceptance.
REQ-028 In the cycle after reset: out_valid=0, out_fire=0, hazard=0, fwd_*_sel=0, and in_ready=~stall.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries without retiring any.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the XZR constant (5'd31) and the SELW "no match" value 0.
REQ-031 One sub-module, stage_reg, SHALL implement a single stage: a WIDTH+REGW+3 bit register with load enable and valid clear, instantiated STAGES times through a generate loop.
REQ-032 Forwarding priority search and the occupancy counter SHALL stay in pipe_chain.

Verification (STAGES=3, WIDTH=64)
REQ-033 Reset, then accept data 0xA, rd=3, wr=1 on three consecutive cycles -> out_valid on the 3rd edge after the first accept, out_fire=1 for three cycles, occupancy peaks at 3.
REQ-034 Stage0 = {rd=5, load=1}, src_a=5, in_valid=1 -> hazard=1, in_ready=0; next cycle the load is in stage 1, fwd_a_sel=2, hazard=0.
REQ-035 Stage0 and stage2 both hold rd=7, src_b=7 -> fwd_b_sel=1, with fwd_b_data equal to the stage-0 payload; with rd=31 and src=31 -> fwd_b_sel=0.
REQ-036 stall=1 for 4 cycles with a full pipe -> contents unchanged, out_fire=0, occupancy=3; with flush[1] during the stall -> occupancy=2 next cycle.
REQ-037 Flush of 3'b111 with in_valid=1 and stall=0 -> next cycle only the new entry is valid, occupancy=1.
REQ-038 Assert reset with 3 valid entries -> occupancy=0, no out_fire, all fwd_*_sel=0.
